param_queue: RTL and testbench

//  Parametrised ready/valid FIFO. It is the successor to the fixed 2-entry queue storage and

---
 rtl/param_queue.sv | 91 +++++++++
 tb/tb_param_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_queue.sv
// rtl/param_queue.sv - parametrised ready/valid FIFO with flow-through/pipe modes and occupancy count
module param_queue #(
    parameter int WIDTH = 105,
    parameter int DEPTH = 2,
    parameter bit PIPE  = 1'b0,
    parameter bit FLOW  = 1'b0,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [CW-1:0]    count
);
    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW1  = CW + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
    logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
    logic             maybe_full_q, maybe_full_d;
    logic             ptr_match, empty, full;
    logic             bypass, do_enq, do_deq;
    logic [CW1-1:0]   count_wide;

    assign ptr_match = (enq_ptr_q == deq_ptr_q);
    assign empty     = ptr_match & ~maybe_full_q;
    assign full      = ptr_match & maybe_full_q;

    assign enq_ready = ~full | (PIPE & deq_ready);
    assign deq_valid = ~empty | (FLOW & enq_valid);
    assign deq_bits  = (FLOW && empty) ? enq_bits : mem_q[deq_ptr_q];

    // A flow-through word consumed in the same cycle never touches storage.
    assign bypass = FLOW & empty & deq_ready;
    assign do_enq = enq_valid & enq_ready & ~bypass;
    assign do_deq = deq_valid & deq_ready & ~empty;

    always_comb begin
        enq_ptr_d    = enq_ptr_q;
        deq_ptr_d    = deq_ptr_q;
        maybe_full_d = maybe_full_q;
        if (do_enq) begin
            enq_ptr_d = (enq_ptr_q == LAST) ? '0 : enq_ptr_q + PW'(1);
        end
        if (do_deq) begin
            deq_ptr_d = (deq_ptr_q == LAST) ? '0 : deq_ptr_q + PW'(1);
        end
        if (do_enq != do_deq) begin
            maybe_full_d = do_enq;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enq_ptr_q    <= '0;
            deq_ptr_q    <= '0;
            maybe_full_q <= 1'b0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_enq) begin
            mem_q[enq_ptr_q] <= enq_bits;
        end
    end

    always_comb begin
        count_wide = '0;
        if (ptr_match) begin
            count_wide = maybe_full_q ? CW1'(DEPTH) : '0;
        end else if (enq_ptr_q > deq_ptr_q) begin
            count_wide = CW1'(enq_ptr_q) - CW1'(deq_ptr_q);
        end else begin
            count_wide = CW1'(DEPTH) + CW1'(enq_ptr_q) - CW1'(deq_ptr_q);
        end
    end

    assign count = count_wide[CW-1:0];

endmodule

// File: tb/tb_param_queue.sv
// tb/tb_param_queue.sv - self-checking bench for param_queue across depth/flow/pipe variants
module tb_param_queue;
    localparam int W  = 105;
    localparam int NI = 6;
    // instance: 0 D2, 1 D3, 2 D2 FLOW, 3 D2 PIPE, 4 D1, 5 D5
    localparam int DEP [NI] = '{2, 3, 2, 2, 1, 5};
    localparam int PIP [NI] = '{0, 0, 0, 1, 0, 0};
    localparam int FLO [NI] = '{0, 0, 1, 0, 0, 0};

    logic         clock = 1'b0;
    logic         reset;
    logic         enq_valid, deq_ready;
    logic [W-1:0] enq_bits;
    logic         er_w [NI];
    logic         dv_w [NI];
    logic [W-1:0] db_w [NI];
    logic [1:0]   cnt0, cnt1, cnt2, cnt3;
    logic [0:0]   cnt4;
    logic [2:0]   cnt5;
    int           cn [NI];

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq [NI][5];
    int           mc [NI];

    always #5 clock = ~clock;

    always_comb begin
        cn[0] = int'(cnt0);
        cn[1] = int'(cnt1);
        cn[2] = int'(cnt2);
        cn[3] = int'(cnt3);
        cn[4] = int'(cnt4);
        cn[5] = int'(cnt5);
    end

    param_queue #(.WIDTH(W), .DEPTH(2), .PIPE(1'b0), .FLOW(1'b0)) u_d2 (
        .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(er_w[0]), .enq_bits(enq_bits),
        .deq_valid(dv_w[0]), .deq_ready(deq_ready), .deq_bits(db_w[0]), .count(cnt0));
    param_queue #(.WIDTH(W), .DEPTH(3), .PIPE(1'b0), .FLOW(1'b0)) u_d3 (
        .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(er_w[1]), .enq_bits(enq_bits),
        .deq_valid(dv_w[1]), .deq_ready(deq_ready), .deq_bits(db_w[1]), .count(cnt1));
    param_queue #(.WIDTH(W), .DEPTH(2), .PIPE(1'b0), .FLOW(1'b1)) u_flow (
        .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(er_w[2]), .enq_bits(enq_bits),
        .deq_valid(dv_w[2]), .deq_ready(deq_ready), .deq_bits(db_w[2]), .count(cnt2));
    param_queue #(.WIDTH(W), .DEPTH(2), .PIPE(1'b1), .FLOW(1'b0)) u_pipe (
        .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(er_w[3]), .enq_bits(enq_bits),
        .deq_valid(dv_w[3]), .deq_ready(deq_ready), .deq_bits(db_w[3]), .count(cnt3));
    param_queue #(.WIDTH(W), .DEPTH(1), .PIPE(1'b0), .FLOW(1'b0)) u_d1 (
        .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(er_w[4]), .enq_bits(enq_bits),
        .deq_valid(dv_w[4]), .deq_ready(deq_ready), .deq_bits(db_w[4]), .count(cnt4));
    param_queue #(.WIDTH(W), .DEPTH(5), .PIPE(1'b0), .FLOW(1'b0)) u_d5 (
        .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(er_w[5]), .enq_bits(enq_bits),
        .deq_valid(dv_w[5]), .deq_ready(deq_ready), .deq_bits(db_w[5]), .count(cnt5));

    task automatic chk_b(input string nm, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b expected %b at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string nm, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ev, input logic [W-1:0] b, input logic dr);
        enq_valid = ev;
        enq_bits  = b;
        deq_ready = dr;
        #1;
    endtask

    // Checks every instance against a list-of-words model, advances the model, then waits a cycle.
    task automatic step(input logic ev, input logic [W-1:0] b, input logic dr);
        drive(ev, b, dr);
        for (int i = 0; i < NI; i++) begin
            bit           is_full, is_empty, x_er, x_dv, fe, fd;
            logic [W-1:0] x_db;
            is_full  = (mc[i] == DEP[i]);
            is_empty = (mc[i] == 0);
            x_er     = !is_full || (PIP[i] == 1 && dr);
            x_dv     = !is_empty || (FLO[i] == 1 && ev);
            x_db     = is_empty ? b : mq[i][0];
            chk_b("m_enq_ready", i, er_w[i], x_er);
            chk_b("m_deq_valid", i, dv_w[i], x_dv);
            chk_i("m_count", i, cn[i], mc[i]);
            if (x_dv) chk_w("m_deq_bits", i, db_w[i], x_db);
            checks++;
            if (cn[i] > DEP[i]) begin
                errors++;
                $display("FAIL count_bound[%0d] got %0d limit %0d", i, cn[i], DEP[i]);
            end
            fe = ev && x_er;
            fd = x_dv && dr;
            if (!(FLO[i] == 1 && is_empty && fe && dr)) begin
                if (fd) begin
                    for (int k = 0; k < 4; k++) mq[i][k] = mq[i][k+1];
                    mc[i]--;
                end
                if (fe) begin
                    mq[i][mc[i]] = b;
                    mc[i]++;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic drain();
        repeat (6) step(1'b0, '0, 1'b1);
    endtask

    typedef struct {
        logic         ev;
        logic [W-1:0] b;
        logic         dr;
        logic         er;
        logic         dv;
        logic [W-1:0] db;
        int           cnt;
    } vec_t;

    vec_t tv [6];

    initial begin
        tv[0] = '{1'b1, W'(1),     1'b0, 1'b1, 1'b0, W'(0), 0};
        tv[1] = '{1'b1, W'(2),     1'b0, 1'b1, 1'b1, W'(1), 1};
        tv[2] = '{1'b1, W'('h77),  1'b0, 1'b0, 1'b1, W'(1), 2};
        tv[3] = '{1'b0, W'(0),     1'b1, 1'b0, 1'b1, W'(1), 2};
        tv[4] = '{1'b0, W'(0),     1'b1, 1'b1, 1'b1, W'(2), 1};
        tv[5] = '{1'b0, W'(0),     1'b0, 1'b1, 1'b0, W'(0), 0};

        for (int i = 0; i < NI; i++) mc[i] = 0;
        reset = 1'b1;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        enq_bits = '0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk_b("rst_enq_ready", i, er_w[i], 1'b1);
            chk_b("rst_deq_valid", i, dv_w[i], 1'b0);
            chk_i("rst_count", i, cn[i], 0);
        end
        @(negedge clock);
        reset = 1'b0;

        // fill to full, ignore enq while full, then drain in order
        for (int v = 0; v < 6; v++) begin
            drive(tv[v].ev, tv[v].b, tv[v].dr);
            chk_b("t1_enq_ready", v, er_w[0], tv[v].er);
            chk_b("t1_deq_valid", v, dv_w[0], tv[v].dv);
            chk_i("t1_count", v, cn[0], tv[v].cnt);
            if (tv[v].dv) chk_w("t1_deq_bits", v, db_w[0], tv[v].db);
            step(tv[v].ev, tv[v].b, tv[v].dr);
        end
        drain();

        // back-to-back streaming through DEPTH=3 wraps both pointers
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, W'(100 + k), 1'b1);
            chk_i("t2_count", k, cn[1], (k == 0) ? 0 : 1);
            chk_b("t2_deq_valid", k, dv_w[1], k != 0);
            if (k != 0) chk_w("t2_deq_bits", k, db_w[1], W'(99 + k));
            step(1'b1, W'(100 + k), 1'b1);
        end
        drain();

        // flow-through on empty
        drive(1'b1, W'('hABC), 1'b1);
        chk_b("t3_deq_valid", 0, dv_w[2], 1'b1);
        chk_w("t3_deq_bits", 0, db_w[2], W'('hABC));
        chk_i("t3_count", 0, cn[2], 0);
        step(1'b1, W'('hABC), 1'b1);
        drive(1'b0, '0, 1'b0);
        chk_i("t3_count_after", 0, cn[2], 0);
        chk_b("t3_deq_valid_after", 0, dv_w[2], 1'b0);
        step(1'b0, '0, 1'b0);
        drain();

        // pipe mode on a full queue vs. plain mode
        step(1'b1, W'('hA1), 1'b0);
        step(1'b1, W'('hB2), 1'b0);
        drive(1'b1, W'('hC3), 1'b1);
        chk_b("t4_pipe_enq_ready", 3, er_w[3], 1'b1);
        chk_b("t4_plain_enq_ready", 0, er_w[0], 1'b0);
        chk_w("t4_pipe_deq_bits", 3, db_w[3], W'('hA1));
        step(1'b1, W'('hC3), 1'b1);
        drive(1'b0, '0, 1'b0);
        chk_i("t4_pipe_count", 3, cn[3], 2);
        chk_w("t4_pipe_head", 3, db_w[3], W'('hB2));
        chk_i("t4_plain_count", 0, cn[0], 1);
        step(1'b0, '0, 1'b0);
        drain();

        // asynchronous reset between edges with two entries held
        step(1'b1, W'(11), 1'b0);
        step(1'b1, W'(22), 1'b0);
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_b("t5_deq_valid", 0, dv_w[0], 1'b0);
        chk_i("t5_count", 0, cn[0], 0);
        chk_b("t5_enq_ready", 0, er_w[0], 1'b1);
        for (int i = 0; i < NI; i++) mc[i] = 0;
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, W'(33), 1'b0);
        chk_b("t5_deq_valid_pre", 0, dv_w[0], 1'b0);
        step(1'b1, W'(33), 1'b0);
        drive(1'b0, '0, 1'b0);
        chk_b("t5_deq_valid_post", 0, dv_w[0], 1'b1);
        chk_w("t5_deq_bits_post", 0, db_w[0], W'(33));
        chk_i("t5_count_post", 0, cn[0], 1);
        step(1'b0, '0, 1'b0);
        drain();

        // random traffic with phases biased toward full and toward empty
        for (int c = 0; c < 10000; c++) begin
            logic         ev, dr;
            logic [127:0] r;
            r  = {$urandom(), $urandom(), $urandom(), $urandom()};
            ev = ($urandom() % 4) != 0;
            if (c < 3000)      dr = ($urandom() % 4) == 0;
            else if (c < 6000) dr = ($urandom() % 4) != 0;
            else               dr = ($urandom() % 2) == 0;
            step(ev, r[W-1:0], dr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
